writeback_stage: RTL and testbench

WRITEBACK_STAGE -- requirements
Module: writeback_stage

---
 rtl/writeback_stage_pkg.sv | 31 +++
 rtl/writeback_stage_load_extend.sv | 50 +++++
 rtl/writeback_stage.sv | 129 ++++++++++++
 tb/tb_writeback_stage.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/writeback_stage_pkg.sv
// Shared core definitions for the writeback stage: result-select encoding,
// load funct3 codes, stage FSM states and load extension helpers.
package writeback_stage_pkg;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_LOAD = 2'd1,
        WB_PC4  = 2'd2,
        WB_RSVD = 2'd3
    } wb_sel_e;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } wb_state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    function automatic logic [31:0] sext8(input logic [7:0] b);
        return {{24{b[7]}}, b};
    endfunction

    function automatic logic [31:0] sext16(input logic [15:0] h);
        return {{16{h[15]}}, h};
    endfunction

endpackage

// File: rtl/writeback_stage_load_extend.sv
// Load lane selection and sign/zero extension; flags misaligned and
// reserved load encodings.
module load_extend
    import writeback_stage_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] word,
    output logic [31:0] data,
    output logic        error
);

    logic [31:0] shifted_s;

    // Bring the addressed byte lane down to bit 0 (little-endian lanes).
    assign shifted_s = word >> {offset, 3'b000};

    // Extension per load type; reserved encodings and bad alignment set error.
    always_comb begin
        data  = 32'd0;
        error = 1'b0;
        case (funct3)
            F3_LB:  data = sext8(shifted_s[7:0]);
            F3_LBU: data = {24'd0, shifted_s[7:0]};
            F3_LH: begin
                if (offset == 2'd3) begin
                    error = 1'b1;
                end else begin
                    data = sext16(shifted_s[15:0]);
                end
            end
            F3_LHU: begin
                if (offset == 2'd3) begin
                    error = 1'b1;
                end else begin
                    data = {16'd0, shifted_s[15:0]};
                end
            end
            F3_LW: begin
                if (offset != 2'd0) begin
                    error = 1'b1;
                end else begin
                    data = word;
                end
            end
            default: error = 1'b1;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// Single-entry writeback stage: captures the final result at accept time,
// drives the register-file write port and forwarding path, counts retires.
module writeback_stage
    import writeback_stage_pkg::*;
(
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        mem_valid_i,
    output logic        mem_ready_o,
    input  logic [4:0]  mem_rd_i,
    input  logic        mem_regwrite_i,
    input  logic [1:0]  mem_wbsel_i,
    input  logic [31:0] mem_alu_result_i,
    input  logic [31:0] mem_pc4_i,
    input  logic [31:0] mem_load_data_i,
    input  logic [2:0]  mem_funct3_i,
    input  logic        flush_i,
    input  logic        hold_i,
    output logic        regwrite_o,
    output logic [4:0]  rd_o,
    output logic [31:0] wd_o,
    output logic        fwd_valid_o,
    output logic [4:0]  fwd_rd_o,
    output logic [31:0] fwd_data_o,
    output logic        load_err_o,
    output logic [63:0] instret_o
);

    wb_state_e   state_r;
    wb_state_e   state_nxt_s;
    wb_sel_e     sel_s;
    logic        retire_s;
    logic        accept_s;
    logic [31:0] ld_data_s;
    logic        ld_err_s;
    logic [31:0] result_s;
    logic        err_s;
    logic [4:0]  rd_r;
    logic [31:0] wd_r;
    logic        wr_en_r;
    logic        err_r;
    logic [63:0] instret_r;

    load_extend u_load_extend (
        .funct3 (mem_funct3_i),
        .offset (mem_alu_result_i[1:0]),
        .word   (mem_load_data_i),
        .data   (ld_data_s),
        .error  (ld_err_s)
    );

    assign sel_s    = wb_sel_e'(mem_wbsel_i);
    assign retire_s = (state_r == ST_FULL) && !hold_i && !flush_i;
    // Ready is gated by reset so the upstream sees no acceptance during reset.
    assign mem_ready_o = ((state_r == ST_EMPTY) || retire_s) && !flush_i && reset_i;
    assign accept_s    = mem_valid_i && mem_ready_o;

    // Result select; the reserved encoding falls back to the ALU result.
    always_comb begin
        result_s = mem_alu_result_i;
        err_s    = 1'b0;
        case (sel_s)
            WB_ALU:  result_s = mem_alu_result_i;
            WB_LOAD: begin
                result_s = ld_data_s;
                err_s    = ld_err_s;
            end
            WB_PC4:  result_s = mem_pc4_i;
            default: result_s = mem_alu_result_i;
        endcase
    end

    // Next-state: flush empties, accept fills, a bare retire empties.
    always_comb begin
        state_nxt_s = state_r;
        if (flush_i) begin
            state_nxt_s = ST_EMPTY;
        end else if (accept_s) begin
            state_nxt_s = ST_FULL;
        end else if (retire_s) begin
            state_nxt_s = ST_EMPTY;
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Stage FSM state register.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_r <= ST_EMPTY;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Payload capture; write enable is pre-qualified so retire is a single AND.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            rd_r    <= 5'd0;
            wd_r    <= 32'd0;
            wr_en_r <= 1'b0;
            err_r   <= 1'b0;
        end else if (accept_s) begin
            rd_r    <= mem_rd_i;
            wd_r    <= result_s;
            wr_en_r <= mem_regwrite_i && (mem_rd_i != 5'd0) && !err_s;
            err_r   <= err_s;
        end
    end

    // Retired-instruction counter, wraps naturally at 2^64.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            instret_r <= 64'd0;
        end else if (retire_s) begin
            instret_r <= instret_r + 64'd1;
        end
    end

    assign regwrite_o  = retire_s && wr_en_r;
    assign load_err_o  = retire_s && err_r;
    assign fwd_valid_o = (state_r == ST_FULL) && wr_en_r;
    assign rd_o        = rd_r;
    assign wd_o        = wd_r;
    assign fwd_rd_o    = rd_r;
    assign fwd_data_o  = wd_r;
    assign instret_o   = instret_r;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: a table of single-instruction vectors
// plus hand-written sequences for back-to-back, hold, flush and reset.
module tb_writeback_stage;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        mem_valid_i;
    logic        mem_ready_o;
    logic [4:0]  mem_rd_i;
    logic        mem_regwrite_i;
    logic [1:0]  mem_wbsel_i;
    logic [31:0] mem_alu_result_i;
    logic [31:0] mem_pc4_i;
    logic [31:0] mem_load_data_i;
    logic [2:0]  mem_funct3_i;
    logic        flush_i;
    logic        hold_i;
    logic        regwrite_o;
    logic [4:0]  rd_o;
    logic [31:0] wd_o;
    logic        fwd_valid_o;
    logic [4:0]  fwd_rd_o;
    logic [31:0] fwd_data_o;
    logic        load_err_o;
    logic [63:0] instret_o;

    int n_cmp = 0;
    int n_bad = 0;
    logic [63:0] exp_instret;

    writeback_stage dut (
        .clk_i            (clk_i),
        .reset_i          (reset_i),
        .mem_valid_i      (mem_valid_i),
        .mem_ready_o      (mem_ready_o),
        .mem_rd_i         (mem_rd_i),
        .mem_regwrite_i   (mem_regwrite_i),
        .mem_wbsel_i      (mem_wbsel_i),
        .mem_alu_result_i (mem_alu_result_i),
        .mem_pc4_i        (mem_pc4_i),
        .mem_load_data_i  (mem_load_data_i),
        .mem_funct3_i     (mem_funct3_i),
        .flush_i          (flush_i),
        .hold_i           (hold_i),
        .regwrite_o       (regwrite_o),
        .rd_o             (rd_o),
        .wd_o             (wd_o),
        .fwd_valid_o      (fwd_valid_o),
        .fwd_rd_o         (fwd_rd_o),
        .fwd_data_o       (fwd_data_o),
        .load_err_o       (load_err_o),
        .instret_o        (instret_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [1:0]  sel;
        logic [2:0]  f3;
        logic [31:0] alu;
        logic [31:0] pc4;
        logic [31:0] ld;
        logic [4:0]  rd;
        logic        rw;
        logic        exp_we;
        logic [31:0] exp_wd;
        logic        exp_err;
    } vec_t;

    vec_t vecs[17];

    function automatic vec_t mk(input logic [1:0] sel, input logic [2:0] f3,
                                input logic [31:0] alu, input logic [31:0] pc4,
                                input logic [31:0] ld, input logic [4:0] rd,
                                input logic rw, input logic exp_we,
                                input logic [31:0] exp_wd, input logic exp_err);
        vec_t v;
        v.sel = sel; v.f3 = f3; v.alu = alu; v.pc4 = pc4; v.ld = ld;
        v.rd = rd; v.rw = rw; v.exp_we = exp_we; v.exp_wd = exp_wd; v.exp_err = exp_err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] sel, input logic [2:0] f3, input logic [31:0] alu,
                         input logic [31:0] pc4, input logic [31:0] ld, input logic [4:0] rd,
                         input logic rw);
        mem_valid_i      = 1'b1;
        mem_wbsel_i      = sel;
        mem_funct3_i     = f3;
        mem_alu_result_i = alu;
        mem_pc4_i        = pc4;
        mem_load_data_i  = ld;
        mem_rd_i         = rd;
        mem_regwrite_i   = rw;
    endtask

    initial begin
        vecs[0]  = mk(2'd0, 3'b000, 32'h1234_5678, 32'h0, 32'h0,         5'd5,  1'b1, 1'b1, 32'h1234_5678, 1'b0);
        vecs[1]  = mk(2'd2, 3'b000, 32'hDEAD_BEEF, 32'h0000_0104, 32'h0, 5'd6,  1'b1, 1'b1, 32'h0000_0104, 1'b0);
        vecs[2]  = mk(2'd3, 3'b000, 32'h0BAD_CAFE, 32'h0000_0200, 32'h0, 5'd7,  1'b1, 1'b1, 32'h0BAD_CAFE, 1'b0);
        vecs[3]  = mk(2'd1, 3'b000, 32'h0000_1001, 32'h0, 32'h80FF_7F01, 5'd8,  1'b1, 1'b1, 32'h0000_007F, 1'b0);
        vecs[4]  = mk(2'd1, 3'b000, 32'h0000_1002, 32'h0, 32'h80FF_7F01, 5'd9,  1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0);
        vecs[5]  = mk(2'd1, 3'b100, 32'h0000_1003, 32'h0, 32'h80FF_7F01, 5'd10, 1'b1, 1'b1, 32'h0000_0080, 1'b0);
        vecs[6]  = mk(2'd1, 3'b001, 32'h0000_1002, 32'h0, 32'h80FF_7F01, 5'd11, 1'b1, 1'b1, 32'hFFFF_80FF, 1'b0);
        vecs[7]  = mk(2'd1, 3'b101, 32'h0000_1000, 32'h0, 32'h80FF_7F01, 5'd12, 1'b1, 1'b1, 32'h0000_7F01, 1'b0);
        vecs[8]  = mk(2'd1, 3'b001, 32'h0000_1001, 32'h0, 32'h80FF_7F01, 5'd13, 1'b1, 1'b1, 32'hFFFF_FF7F, 1'b0);
        vecs[9]  = mk(2'd1, 3'b010, 32'h0000_1000, 32'h0, 32'h80FF_7F01, 5'd14, 1'b1, 1'b1, 32'h80FF_7F01, 1'b0);
        vecs[10] = mk(2'd1, 3'b010, 32'h0000_1002, 32'h0, 32'h80FF_7F01, 5'd15, 1'b1, 1'b0, 32'h0,         1'b1);
        vecs[11] = mk(2'd1, 3'b001, 32'h0000_1003, 32'h0, 32'h80FF_7F01, 5'd16, 1'b1, 1'b0, 32'h0,         1'b1);
        vecs[12] = mk(2'd1, 3'b011, 32'h0000_1000, 32'h0, 32'h80FF_7F01, 5'd17, 1'b1, 1'b0, 32'h0,         1'b1);
        vecs[13] = mk(2'd1, 3'b101, 32'h0000_1003, 32'h0, 32'h80FF_7F01, 5'd18, 1'b1, 1'b0, 32'h0,         1'b1);
        vecs[14] = mk(2'd0, 3'b000, 32'h5555_AAAA, 32'h0, 32'h0,         5'd19, 1'b0, 1'b0, 32'h5555_AAAA, 1'b0);
        vecs[15] = mk(2'd0, 3'b000, 32'h7777_0000, 32'h0, 32'h0,         5'd0,  1'b1, 1'b0, 32'h7777_0000, 1'b0);
        vecs[16] = mk(2'd0, 3'b011, 32'h0000_0003, 32'h0, 32'h0,         5'd20, 1'b1, 1'b1, 32'h0000_0003, 1'b0);

        reset_i = 1'b0; flush_i = 1'b0; hold_i = 1'b0;
        drive(2'd0, 3'b000, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
        mem_valid_i = 1'b0;
        #1;
        chk("rst_ready", {63'd0, mem_ready_o}, 64'd0);
        chk("rst_regwrite", {63'd0, regwrite_o}, 64'd0);
        chk("rst_fwd_valid", {63'd0, fwd_valid_o}, 64'd0);
        chk("rst_load_err", {63'd0, load_err_o}, 64'd0);
        chk("rst_rd", {59'd0, rd_o}, 64'd0);
        chk("rst_wd", {32'd0, wd_o}, 64'd0);
        chk("rst_instret", instret_o, 64'd0);
        repeat (2) @(negedge clk_i);
        reset_i = 1'b1;
        #1;
        chk("post_rst_ready", {63'd0, mem_ready_o}, 64'd1);

        // Back-to-back ALU writes to x1, x2, x0.
        @(negedge clk_i);
        drive(2'd0, 3'b000, 32'h0000_0011, 32'h0, 32'h0, 5'd1, 1'b1);
        @(negedge clk_i);
        drive(2'd0, 3'b000, 32'h0000_0022, 32'h0, 32'h0, 5'd2, 1'b1);
        #1;
        chk("b2b_we1", {63'd0, regwrite_o}, 64'd1);
        chk("b2b_rd1", {59'd0, rd_o}, 64'd1);
        chk("b2b_wd1", {32'd0, wd_o}, 64'h11);
        chk("b2b_ready1", {63'd0, mem_ready_o}, 64'd1);
        @(negedge clk_i);
        drive(2'd0, 3'b000, 32'h0000_0033, 32'h0, 32'h0, 5'd0, 1'b1);
        #1;
        chk("b2b_we2", {63'd0, regwrite_o}, 64'd1);
        chk("b2b_rd2", {59'd0, rd_o}, 64'd2);
        chk("b2b_wd2", {32'd0, wd_o}, 64'h22);
        @(negedge clk_i);
        mem_valid_i = 1'b0;
        #1;
        chk("b2b_we_x0", {63'd0, regwrite_o}, 64'd0);
        chk("b2b_fwd_x0", {63'd0, fwd_valid_o}, 64'd0);
        @(negedge clk_i);
        #1;
        chk("b2b_instret", instret_o, 64'd3);
        exp_instret = 64'd3;

        // Hold for four cycles while FULL.
        @(negedge clk_i);
        drive(2'd0, 3'b000, 32'h0000_A5A5, 32'h0, 32'h0, 5'd9, 1'b1);
        @(negedge clk_i);
        mem_valid_i = 1'b0;
        hold_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("hold%0d_ready", i), {63'd0, mem_ready_o}, 64'd0);
            chk($sformatf("hold%0d_fwd", i), {63'd0, fwd_valid_o}, 64'd1);
            chk($sformatf("hold%0d_we", i), {63'd0, regwrite_o}, 64'd0);
            @(negedge clk_i);
        end
        hold_i = 1'b0;
        #1;
        chk("hold_release_we", {63'd0, regwrite_o}, 64'd1);
        chk("hold_release_wd", {32'd0, wd_o}, 64'hA5A5);
        chk("hold_fwd_data", {32'd0, fwd_data_o}, 64'hA5A5);
        chk("hold_fwd_rd", {59'd0, fwd_rd_o}, 64'd9);
        @(negedge clk_i);
        exp_instret = exp_instret + 64'd1;
        #1;
        chk("hold_instret", instret_o, exp_instret);

        // Flush while FULL with a simultaneous valid.
        drive(2'd0, 3'b000, 32'h0000_00F0, 32'h0, 32'h0, 5'd10, 1'b1);
        @(negedge clk_i);
        drive(2'd0, 3'b000, 32'h0000_00F1, 32'h0, 32'h0, 5'd11, 1'b1);
        flush_i = 1'b1;
        #1;
        chk("flush_ready", {63'd0, mem_ready_o}, 64'd0);
        chk("flush_we", {63'd0, regwrite_o}, 64'd0);
        @(negedge clk_i);
        flush_i = 1'b0;
        mem_valid_i = 1'b0;
        #1;
        chk("flush_empty_fwd", {63'd0, fwd_valid_o}, 64'd0);
        chk("flush_empty_ready", {63'd0, mem_ready_o}, 64'd1);
        chk("flush_instret", instret_o, exp_instret);
        @(negedge clk_i);
        #1;
        chk("flush_no_accept_we", {63'd0, regwrite_o}, 64'd0);
        chk("flush_instret2", instret_o, exp_instret);

        // Reset asserted mid-hold, then a PC4 instruction after release.
        drive(2'd2, 3'b000, 32'h0, 32'h0000_0200, 32'h0, 5'd12, 1'b1);
        @(negedge clk_i);
        mem_valid_i = 1'b0;
        hold_i = 1'b1;
        @(posedge clk_i);
        #2;
        reset_i = 1'b0;
        #1;
        chk("midrst_fwd", {63'd0, fwd_valid_o}, 64'd0);
        chk("midrst_we", {63'd0, regwrite_o}, 64'd0);
        chk("midrst_err", {63'd0, load_err_o}, 64'd0);
        chk("midrst_rd", {59'd0, rd_o}, 64'd0);
        chk("midrst_wd", {32'd0, wd_o}, 64'd0);
        chk("midrst_instret", instret_o, 64'd0);
        chk("midrst_ready", {63'd0, mem_ready_o}, 64'd0);
        @(negedge clk_i);
        reset_i = 1'b1;
        hold_i = 1'b0;
        drive(2'd2, 3'b000, 32'h0, 32'h0000_0104, 32'h0, 5'd7, 1'b1);
        @(negedge clk_i);
        mem_valid_i = 1'b0;
        #1;
        chk("postrst_we", {63'd0, regwrite_o}, 64'd1);
        chk("postrst_wd", {32'd0, wd_o}, 64'h104);
        chk("postrst_rd", {59'd0, rd_o}, 64'd7);
        @(negedge clk_i);
        exp_instret = 64'd1;
        #1;
        chk("postrst_instret", instret_o, exp_instret);

        // Table-driven single-instruction vectors.
        for (int i = 0; i < 17; i++) begin
            @(negedge clk_i);
            drive(vecs[i].sel, vecs[i].f3, vecs[i].alu, vecs[i].pc4, vecs[i].ld,
                  vecs[i].rd, vecs[i].rw);
            #1;
            chk($sformatf("vec%0d_ready", i), {63'd0, mem_ready_o}, 64'd1);
            @(negedge clk_i);
            mem_valid_i = 1'b0;
            #1;
            chk($sformatf("vec%0d_we", i), {63'd0, regwrite_o}, {63'd0, vecs[i].exp_we});
            chk($sformatf("vec%0d_fwd", i), {63'd0, fwd_valid_o}, {63'd0, vecs[i].exp_we});
            chk($sformatf("vec%0d_err", i), {63'd0, load_err_o}, {63'd0, vecs[i].exp_err});
            chk($sformatf("vec%0d_rd", i), {59'd0, rd_o}, {59'd0, vecs[i].rd});
            if (!vecs[i].exp_err) begin
                chk($sformatf("vec%0d_wd", i), {32'd0, wd_o}, {32'd0, vecs[i].exp_wd});
            end
            @(negedge clk_i);
            exp_instret = exp_instret + 64'd1;
            #1;
            chk($sformatf("vec%0d_err_gone", i), {63'd0, load_err_o}, 64'd0);
            chk($sformatf("vec%0d_we_gone", i), {63'd0, regwrite_o}, 64'd0);
            chk($sformatf("vec%0d_instret", i), instret_o, exp_instret);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
